// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans a 4x3 membrane keypad one column at a time, collapses each full
// scan into a single key code (or NONE for no key / multi-press / ghosting),
// debounces that code over consecutive scans and drives a one-hot digit bus
// plus active-low start (#) and clear (*) strobes for the front panel.
//
// Build option: define KEYPAD_PULSE_EN to make `keypad` a single-clock pulse
// on press acceptance instead of a level held for the whole press.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 1,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] rows_n,
    output logic [2:0] col_n,
    output logic [9:0] keypad,
    output logic       startn,
    output logic       clearn,
    output logic       key_valid
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [3:0]    CODE_NONE  = 4'd15;
    localparam logic [3:0]    CODE_STAR  = 4'd10;
    localparam logic [3:0]    CODE_HASH  = 4'd11;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    // Key code of the switch at (row, column); row 3 holds *, 0, #.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        if (r != 2'd3) begin
            code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end else begin
            case (c)
                2'd0:    code = CODE_STAR;
                2'd1:    code = 4'd0;
                default: code = CODE_HASH;
            endcase
        end
        return code;
    endfunction

    // Scan state
    logic [1:0]    col_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    hits_q;      // hits seen so far this scan, saturating at 2
    logic [3:0]    code_acc_q;  // code of the most recent hit this scan

    // Debounce FSM state and registered outputs
    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    keypad_q, keypad_d;
    logic          startn_q, startn_d;
    logic          clearn_q, clearn_d;
    logic          valid_q, valid_d;

    logic          sample;
    logic          scan_done;
    logic [3:0]    row_hit;
    logic [3:0]    row_code [4];
    logic [2:0]    col_hits;
    logic [3:0]    col_code;
    logic [2:0]    scan_hits;
    logic [3:0]    scan_code;

    assign sample    = (dwell_q == DWELL_LAST);
    assign scan_done = sample && (col_q == 2'd2);
    assign col_n     = ~(3'b001 << col_q);

    // Per-row hit flag and the key that hit would mean in the driven column
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign row_hit[gi]  = ~rows_n[gi];
            assign row_code[gi] = key_code(2'(gi), col_q);
        end
    endgenerate

    // Fold the current column's rows into the running scan result
    always_comb begin
        col_hits = 3'd0;
        col_code = code_acc_q;
        for (int r = 0; r < 4; r++) begin
            if (row_hit[r]) begin
                col_hits = col_hits + 3'd1;
                col_code = row_code[r];
            end
        end
        scan_hits = {1'b0, hits_q} + col_hits;
        scan_code = (scan_hits == 3'd1) ? col_code : CODE_NONE;
    end

    // Column drive, dwell timing and per-scan hit accumulation
    always_ff @(posedge clock) begin
        if (!resetn) begin
            col_q      <= 2'd0;
            dwell_q    <= '0;
            hits_q     <= 2'd0;
            code_acc_q <= CODE_NONE;
        end else if (sample) begin
            dwell_q <= '0;
            col_q   <= (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
            if (scan_done) begin
                hits_q     <= 2'd0;
                code_acc_q <= CODE_NONE;
            end else begin
                hits_q     <= (scan_hits >= 3'd2) ? 2'd2 : scan_hits[1:0];
                code_acc_q <= col_code;
            end
        end else begin
            dwell_q <= dwell_q + DW'(1);
        end
    end

    // Debounce next-state, evaluated only when a full scan has completed
    always_comb begin
        logic [CW-1:0] cnt_inc;
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        cnt_inc = (cnt_q < CNT_TARGET) ? cnt_q + CW'(1) : cnt_q;
        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (scan_code != CODE_NONE) begin
                        cand_d  = scan_code;
                        cnt_d   = CW'(1);
                        state_d = (DEBOUNCE_SCANS == 1) ? PRESSED : DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (scan_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_TARGET) state_d = PRESSED;
                    end else if (scan_code == CODE_NONE) begin
                        state_d = IDLE;
                    end else begin
                        cand_d = scan_code;
                        cnt_d  = CW'(1);
                    end
                end
                PRESSED: begin
                    if (scan_code != cand_q) begin
                        cnt_d   = CW'(1);
                        state_d = (DEBOUNCE_SCANS == 1) ? IDLE : DEB_REL;
                    end
                end
                default: begin
                    if (scan_code == cand_q) begin
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_TARGET) state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // Output decode from the next state so outputs move on the same edge
    always_comb begin
        logic       active;
        logic [9:0] digit_onehot;
        active       = (state_d == PRESSED) || (state_d == DEB_REL);
        digit_onehot = (cand_d < 4'd10) ? (10'd1 << cand_d) : 10'd0;
`ifdef KEYPAD_PULSE_EN
        keypad_d = (scan_done && (state_d == PRESSED) &&
                    ((state_q == IDLE) || (state_q == DEB_PRESS))) ? digit_onehot : 10'd0;
`else
        keypad_d = active ? digit_onehot : 10'd0;
`endif
        startn_d = !(active && (cand_d == CODE_HASH));
        clearn_d = !(active && (cand_d == CODE_STAR));
        valid_d  = active;
    end

    // Debounce FSM state and registered front-panel outputs
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cand_q   <= CODE_NONE;
            cnt_q    <= '0;
            keypad_q <= 10'd0;
            startn_q <= 1'b1;
            clearn_q <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            keypad_q <= keypad_d;
            startn_q <= startn_d;
            clearn_q <= clearn_d;
            valid_q  <= valid_d;
        end
    end

    assign keypad    = keypad_q;
    assign startn    = startn_q;
    assign clearn    = clearn_q;
    assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Testbench for keypad_matrix_scanner: a keypad model drives rows_n from
// col_n, the stimulus process queues expected output changes with a cycle
// window, and a monitor pops and checks each observed output change.
module tb_keypad_matrix_scanner;

    logic       clock;
    logic       resetn;
    logic [3:0] rows_n;
    logic [2:0] col_n;
    logic [9:0] keypad;
    logic       startn;
    logic       clearn;
    logic       key_valid;

    keypad_matrix_scanner dut (
        .clock     (clock),
        .resetn    (resetn),
        .rows_n    (rows_n),
        .col_n     (col_n),
        .keypad    (keypad),
        .startn    (startn),
        .clearn    (clearn),
        .key_valid (key_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [12:0] val;
        int          lo;
        int          hi;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    bit          mon_en = 0;
    logic [2:0]  press_rc [4];
    logic [12:0] snap;
    logic [12:0] prev;

    localparam logic [12:0] IDLE_SNAP = {10'd0, 1'b1, 1'b1, 1'b0};

    assign snap = {keypad, startn, clearn, key_valid};

    always @(posedge clock) cyc <= cyc + 1;

    // Membrane model: a row reads low when a held key sits in the driven column
    always_comb begin
        rows_n = 4'b1111;
        for (int r = 0; r < 4; r++) rows_n[r] = ~|(press_rc[r] & ~col_n);
    end

    // Monitor: every output change must match the next queued expectation
    always @(negedge clock) begin
        if (mon_en && (snap !== prev)) begin
            exp_t e;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, snap);
            end else begin
                e = sb.pop_front();
                if ((snap !== e.val) || (cyc < e.lo) || (cyc > e.hi)) begin
                    fails++;
                    $display("FAIL %s cyc=%0d got=%b required=%b in cycles [%0d,%0d]",
                             e.name, cyc, snap, e.val, e.lo, e.hi);
                end else begin
                    $display("[TB] %s ok cyc=%0d out=%b", e.name, cyc, snap);
                end
            end
            prev = snap;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_ev(input string nm, input logic [9:0] kp, input logic sn,
                             input logic cn, input logic kv, input int lo, input int hi);
        exp_t e;
        e.val  = {kp, sn, cn, kv};
        e.lo   = lo;
        e.hi   = hi;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic check(input string nm, input logic [12:0] got, input logic [12:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%b required=%b", nm, got, req);
        end else begin
            $display("[TB] %s ok value=%b", nm, got);
        end
    endtask

    // Press a digit key, expect acceptance within 9 clocks, hold, release
    task automatic digit_press(input string nm, input int r, input int c,
                               input logic [9:0] onehot, input int hold);
        int t;
        press_rc[r][c] = 1'b1;
        t = cyc;
        expect_ev({nm, "_press"}, onehot, 1'b1, 1'b1, 1'b1, t + 1, t + 9);
`ifdef KEYPAD_PULSE_EN
        expect_ev({nm, "_pulse_end"}, 10'd0, 1'b1, 1'b1, 1'b1, t + 2, t + 10);
`endif
        tick(hold);
        press_rc[r][c] = 1'b0;
        t = cyc;
        expect_ev({nm, "_release"}, 10'd0, 1'b1, 1'b1, 1'b0, t + 1, t + 9);
        tick(12);
    endtask

    initial begin
        int t;
        for (int r = 0; r < 4; r++) press_rc[r] = 3'b000;
        prev   = IDLE_SNAP;
        resetn = 1'b0;
        tick(2);

        // Reset state
        check("reset_col_n", {10'd0, col_n}, {10'd0, 3'b110});
        check("reset_keypad", {3'd0, keypad}, 13'd0);
        check("reset_startn", {12'd0, startn}, 13'd1);
        check("reset_clearn", {12'd0, clearn}, 13'd1);
        check("reset_key_valid", {12'd0, key_valid}, 13'd0);

        resetn = 1'b1;
        mon_en = 1'b1;

        // Column walk after reset release
        tick(1);
        check("scan_col1", {10'd0, col_n}, {10'd0, 3'b101});
        tick(1);
        check("scan_col2", {10'd0, col_n}, {10'd0, 3'b011});
        tick(1);
        check("scan_wrap", {10'd0, col_n}, {10'd0, 3'b110});

        // Key 5 held 30 clocks
        digit_press("key5", 1, 1, 10'b00_0010_0000, 30);

        // Key 2 for only 3 clocks: must be rejected as a bounce
        press_rc[0][1] = 1'b1;
        tick(3);
        press_rc[0][1] = 1'b0;
        tick(12);

        // Keys 1 and 3 together: multi-press is ignored
        press_rc[0][0] = 1'b1;
        press_rc[0][2] = 1'b1;
        tick(15);
        press_rc[0][0] = 1'b0;
        press_rc[0][2] = 1'b0;
        tick(12);

        // # alone drives startn
        press_rc[3][2] = 1'b1;
        t = cyc;
        expect_ev("hash_press", 10'd0, 1'b0, 1'b1, 1'b1, t + 1, t + 9);
        tick(15);
        press_rc[3][2] = 1'b0;
        t = cyc;
        expect_ev("hash_release", 10'd0, 1'b1, 1'b1, 1'b0, t + 1, t + 9);
        tick(12);

        // * alone drives clearn
        press_rc[3][0] = 1'b1;
        t = cyc;
        expect_ev("star_press", 10'd0, 1'b1, 1'b0, 1'b1, t + 1, t + 9);
        tick(15);
        press_rc[3][0] = 1'b0;
        t = cyc;
        expect_ev("star_release", 10'd0, 1'b1, 1'b1, 1'b0, t + 1, t + 9);
        tick(12);

        // Key 7 held across a reset: drop on the reset edge, re-debounce after
        press_rc[2][0] = 1'b1;
        t = cyc;
        expect_ev("key7_press", 10'b00_1000_0000, 1'b1, 1'b1, 1'b1, t + 1, t + 9);
`ifdef KEYPAD_PULSE_EN
        expect_ev("key7_pulse_end", 10'd0, 1'b1, 1'b1, 1'b1, t + 2, t + 10);
`endif
        tick(12);
        resetn = 1'b0;
        t = cyc;
        expect_ev("key7_reset_drop", 10'd0, 1'b1, 1'b1, 1'b0, t + 1, t + 1);
        tick(2);
        resetn = 1'b1;
        t = cyc;
        expect_ev("key7_after_reset", 10'b00_1000_0000, 1'b1, 1'b1, 1'b1, t + 6, t + 6);
`ifdef KEYPAD_PULSE_EN
        expect_ev("key7_after_reset_pulse_end", 10'd0, 1'b1, 1'b1, 1'b1, t + 7, t + 7);
`endif
        tick(15);
        press_rc[2][0] = 1'b0;
        t = cyc;
        expect_ev("key7_release", 10'd0, 1'b1, 1'b1, 1'b0, t + 1, t + 9);
        tick(12);

        // Key 0 held 30 clocks
        digit_press("key0", 3, 1, 10'b00_0000_0001, 30);

        // Every queued expectation must have been observed
        tick(5);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL missing_events got=%0d pending required=0 pending (next %s)",
                     sb.size(), sb[0].name);
        end else begin
            $display("[TB] all_events_seen ok");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Scans a physical 4x3 membrane keypad (keys 1-9, *, 0, #), debounces it, and drives the microwave_controller front-panel inputs.
- Outputs: one-hot 10-bit `keypad`, `startn` (from #) and `clearn` (from *).
- Sits between the board keypad pins and microwave_controller. It is the source end of the one-hot keypad interface that the controller consumes.

Parameters:
- SCAN_DIV, 1, clock cycles each column is driven before its rows are sampled (>=1).
- DEBOUNCE_SCANS, 2, consecutive identical full scans required to accept a press or a release (>=1).

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- resetn  input  1  synchronous active-low reset.
- rows_n  input  4  row sense lines, active-low, pulled up; row0=1,2,3 row1=4,5,6 row2=7,8,9 row3=*,0,#.
- col_n  output  3  column drive, active-low, exactly one bit low at a time; col0 = left column (1,4,7,*).
- keypad  output  10  one-hot digit, bit i = digit i; all zero when no digit is accepted.
- startn  output  1  low while # is accepted as pressed.
- clearn  output  1  low while * is accepted as pressed.
- key_valid  output  1  high while any key is in the accepted-pressed state.

Behaviour:
- Reset (resetn sampled low):
  - col index=0, dwell=0, state IDLE, candidate cleared.
  - col_n=3'b110, keypad=0, startn=1, clearn=1, key_valid=0.
  - Reset wins over every other event.
- Scan:
  - Dwell counter runs 0..SCAN_DIV-1 per column; col_n=~(1<<col).
  - Rows are sampled on the edge where dwell==SCAN_DIV-1, then col advances 0->1->2->0 (wrap).
  - A full scan is 3*SCAN_DIV clocks. "Scan complete" is the sample edge of col 2.
- Scan result:
  - Count asserted row/column hits over the scan.
  - Exactly 1 hit -> scan_code = key code (0-9 digits, 10 = *, 11 = #).
  - 0 hits or >=2 hits (ghost/multi-press) -> scan_code = NONE (15).
- FSM, evaluated only on scan-complete edges; cnt saturates at DEBOUNCE_SCANS:
  - IDLE:
    - scan_code!=NONE -> DEB_PRESS, cand=scan_code, cnt=1.
    - If DEBOUNCE_SCANS==1, go directly to PRESSED instead.
  - DEB_PRESS:
    - scan_code==cand -> cnt+1; reaching DEBOUNCE_SCANS -> PRESSED.
    - scan_code==NONE -> IDLE.
    - Other key -> restart with cand=new, cnt=1.
  - PRESSED:
    - scan_code==cand -> stay.
    - Otherwise -> DEB_REL, cnt=1; if DEBOUNCE_SCANS==1, go directly to IDLE.
  - DEB_REL:
    - scan_code==cand -> back to PRESSED.
    - Otherwise cnt+1; reaching DEBOUNCE_SCANS -> IDLE.
  - No rollover: a second key pressed while the first is held is recognised only after release completes and the FSM re-enters IDLE.
- Outputs:
  - Registered, updated on the same edge as the state change.
  - In PRESSED and DEB_REL:
    - cand 0-9 -> keypad=1<<cand.
    - cand 10 -> clearn=0.
    - cand 11 -> startn=0.
    - key_valid=1.
  - Otherwise keypad=0, startn=1, clearn=1, key_valid=0.
  - At most one of keypad/startn/clearn is active at any time.
- Latency, defaults: press recognised no more than (DEBOUNCE_SCANS+1)*3*SCAN_DIV = 9 clocks after rows_n becomes stable; release likewise.
- Reset mid-press: outputs drop on that edge. A key still held after resetn returns high must be debounced again from IDLE.

Optional Feature:
- KEYPAD_PULSE_EN defined: `keypad` is asserted for exactly one clock, on the edge entering PRESSED from DEB_PRESS or IDLE. It is not re-pulsed on a DEB_REL->PRESSED return. startn, clearn and key_valid remain level.
- Not defined: `keypad` is level, held for the whole PRESSED/DEB_REL period as described above.

Test Plan:
- Reset: resetn=0 for 2 clocks with rows_n=4'b1111 -> col_n=3'b110, keypad=0, startn=1, clearn=1, key_valid=0; after release, col_n cycles 110,101,011 each clock.
- Key 5 (row1 low whenever col_n[1]=0) held 30 clocks -> keypad=10'b00_0010_0000 within 9 clocks, held. Release -> keypad=0 within 9 clocks after release.
- Bounce: key 2 asserted for one full scan (3 clocks) then released -> keypad stays 10'b0, key_valid stays 0.
- Keys 1 and 3 pressed together -> keypad=0, key_valid=0. # alone held -> startn=0, keypad=0. * alone held -> clearn=0.
- Key 7 held, then resetn=0 mid-press -> keypad=0 on the next edge. After resetn=1 -> keypad=10'b00_1000_0000 reappears only after 2 full scans.
- With KEYPAD_PULSE_EN: key 0 held 30 clocks -> keypad=10'b00_0000_0001 for exactly one clock; key_valid high throughout the hold.
